// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end (PC, 1-cycle imem requests, head queue, redirect squash)
//   clk, rst (async, active-low)            clock and reset
//   imem_req/imem_addr, imem_rdata           synchronous instruction memory port, data valid 1 cycle after req
//   redirect_valid/redirect_pc               downstream redirect; flushes queue and drops in-flight data
//   instr_valid/instr_ready                  handshake for the queue head {Instr, PC, PCPlus4}
//   stall_cycles                             cycles with head valid but not accepted (only with FETCH_STALL_CNT_EN)
module fetch_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           Instr,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [ADDR_WIDTH-1:0] PCPlus4
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [ADDR_WIDTH-1:0] fetch_pc, inflight_addr;
    logic                  inflight;
    logic [31:0]           instr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc4_q [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;
    logic                  push, pop;
    // a slot is reserved for the in-flight word, so a push can never overflow
    assign imem_req    = rst & ~redirect_valid & (count + CW'(inflight) < CW'(DEPTH));
    assign imem_addr   = fetch_pc;
    assign instr_valid = count != '0;
    assign push        = inflight & ~redirect_valid;
    assign pop         = instr_valid & instr_ready;
    assign Instr       = instr_q[rd_ptr];
    assign PC          = pc_q[rd_ptr];
    assign PCPlus4     = pc4_q[rd_ptr];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                pc4_q[i]   <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~ADDR_WIDTH'(3);
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= imem_rdata;
                pc_q[wr_ptr]    <= inflight_addr;
                pc4_q[wr_ptr]   <= inflight_addr + ADDR_WIDTH'(4);
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count    <= count + CW'(push) - CW'(pop);
            inflight <= imem_req;
            if (imem_req) begin
                inflight_addr <= fetch_pc;
                fetch_pc      <= fetch_pc + ADDR_WIDTH'(4);
            end
        end
    end
`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if (instr_valid & ~instr_ready & ~&stall_cycles)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end feeding the decode/execute datapath. Owns the program counter and issues word requests to a synchronous (1-cycle latency) instruction memory. Buffers returned words in a small FIFO and presents {Instr, PC, PCPlus4} to decode with a valid/ready handshake. Accepts redirects (branch/jump/JALR targets computed downstream) and squashes all wrong-path work.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
DEPTH, 2, instruction queue entries; power of two, >= 2
ADDR_WIDTH, 32, PC/address width

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-low (0 = in reset)
imem_req  out  1  fetch request this cycle
imem_addr  out  ADDR_WIDTH  word-aligned fetch address
imem_rdata  in  32  instruction word, valid the cycle after imem_req
redirect_valid  in  1  redirect fetch to redirect_pc this cycle
redirect_pc  in  ADDR_WIDTH  redirect target
instr_valid  out  1  queue head valid to decode
instr_ready  in  1  decode accepts head
Instr  out  32  head instruction word
PC  out  ADDR_WIDTH  address of head instruction
PCPlus4  out  ADDR_WIDTH  PC + 4 of head (modulo 2^ADDR_WIDTH)

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, queue empty, no in-flight request, imem_req=0, instr_valid=0, Instr/PC/PCPlus4=0. First imem_req=1 in the first cycle after rst deasserts.
- Request rule: imem_req=1 iff count + inflight < DEPTH and redirect_valid=0. imem_addr=fetch_pc. On issue: fetch_pc <= fetch_pc+4 (wraps 0xFFFF_FFFC -> 0x0000_0000); inflight <= 1, tagged with addr.
- Response: cycle after issue, imem_rdata plus tagged addr pushed to queue tail unless squashed. Max one request in flight.
- Pop: handshake = instr_valid & instr_ready; head advances that edge. Push and pop same cycle allowed at any occupancy, including full (count unchanged).
- Outputs are registered queue-head contents; instr_valid = (count != 0). Min latency request -> instr_valid: 2 cycles (issue, capture, visible).
- Redirect (highest priority): on redirect_valid=1, that edge flushes queue (count=0), drops in-flight response (current cycle's imem_rdata discarded), fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}. imem_req=0 that cycle; fetch resumes next cycle at new target. A handshake in the redirect cycle is still a valid consume (decode sees it); nothing else survives.
- Back-to-back redirects: last one wins; no request issued until a redirect-free cycle.
- Stall: instr_ready=0 with full queue -> imem_req=0, fetch_pc, outputs held stable.
- Reset mid-operation: immediate return to reset state; in-flight response ignored.
- PCPlus4 computed at push time and stored; not recomputed from PC.

Optional Feature:
FETCH_STALL_CNT_EN: when defined, adds output stall_cycles [31:0]: counts cycles with instr_valid=1 & instr_ready=0; cleared by reset, saturates at 0xFFFF_FFFF. When undefined, port and counter absent, no other behaviour change.

Test Plan:
- Reset release, RESET_PC=0, instr_ready=1, imem returns 0x00000013 -> imem_addr 0,4,8,... on consecutive cycles; instr_valid first high 2 cycles after rst release with PC=0, PCPlus4=4.
- instr_ready=0 after release, DEPTH=2 -> exactly 2 pushes (PC 0,4), imem_req low thereafter, outputs hold PC=0; ready=1 -> pops resume, next fetch addr 8.
- Redirect to 0x0000_0102 while queue holds PC 8,12 and request in flight -> queue empties, next imem_addr=0x0000_0100, next instr_valid carries PC=0x100; no PC 8/12/16 seen after redirect edge.
- redirect_valid on cycles N and N+1 (targets 0x40, 0x80) -> only 0x80 fetched; no request at 0x40.
- fetch_pc=0xFFFF_FFFC -> head shows PC=0xFFFF_FFFC, PCPlus4=0; next fetch at 0x0.
- rst asserted mid-stream with request in flight -> instr_valid=0 and imem_req=0 immediately; after release, fetch restarts at RESET_PC; with FETCH_STALL_CNT_EN, stall_cycles=0.
